// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the uDSP I/O data-memory segment:
//   DSP_DWW, DSP_OFFSET_WIDTH : default data word and segment offset widths
//   io_state_t                : frame state (idle / frame in progress)
//   sat_inc                   : saturating increment used by the frame counter
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int DSP_DWW          = 36;
    localparam int DSP_OFFSET_WIDTH = 8;

    typedef enum logic {
        IO_IDLE = 1'b0,
        IO_RUN  = 1'b1
    } io_state_t;

    // Width-agnostic: the caller zero-extends its counter to 32 bits and
    // passes the all-ones value of its own width as the ceiling.
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned maxValue);
        return (value >= maxValue) ? maxValue : value + 1;
    endfunction

endpackage

// File: rtl/dsp_io_segment_if.sv
// -----------------------------------------------------------------------------
// dsp_io_segment_if
// memCtl-side data-segment bus of the I/O segment.
//   readAddress  : segment read offset
//   readData     : read data, returned one cycle after readAddress
//   writeAddress : segment write offset
//   writeData    : write data
//   writeEnable  : write strobe
// Modports: master = memCtl, slave = the segment.
// -----------------------------------------------------------------------------
interface dsp_io_segment_if
    import dsp_pkg::*;
#(
    parameter int DWW         = DSP_DWW,
    parameter int OffsetWidth = DSP_OFFSET_WIDTH
) ();

    logic [OffsetWidth-1:0] readAddress;
    logic [DWW-1:0]         readData;
    logic [OffsetWidth-1:0] writeAddress;
    logic [DWW-1:0]         writeData;
    logic                   writeEnable;

    modport master (
        output readAddress,
        output writeAddress,
        output writeData,
        output writeEnable,
        input  readData
    );

    modport slave (
        input  readAddress,
        input  writeAddress,
        input  writeData,
        input  writeEnable,
        output readData
    );

endinterface

// File: rtl/dsp_io_segment.sv
// -----------------------------------------------------------------------------
// dsp_io_segment
// NCHAN-channel I/O data segment for the uDSP core.
//   - Input samples are snapshotted into an input bank on every start pulse;
//     the core reads that bank through the segment bus (1-cycle latency).
//   - The core writes results into a staging bank; at frame end the whole
//     bank is copied to the outputs at once and out_valid pulses.
//   - Tracks frame length (saturating) and flags frame overrun.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : frame start pulse
//   frame_done       : program finished for this frame (pulse)
//   inputs           : live input samples, NCHAN x DWW
//   outputs          : committed output samples, NCHAN x DWW
//   out_valid        : pulse in the cycle a new commit first appears
//   bus              : memCtl segment bus (read/write offsets and data)
//   busy             : frame in progress
//   overrun          : sticky, start seen before frame_done
//   clear_overrun    : clears overrun (a simultaneous set wins)
//   frame_cycles     : length of the last committed frame, saturating
// -----------------------------------------------------------------------------
module dsp_io_segment
    import dsp_pkg::*;
#(
    parameter int DWW         = DSP_DWW,
    parameter int OffsetWidth = DSP_OFFSET_WIDTH,
    parameter int NCHAN       = 8,
    parameter int CW          = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      frame_done,
    input  logic [NCHAN-1:0][DWW-1:0] inputs,
    output logic [NCHAN-1:0][DWW-1:0] outputs,
    output logic                      out_valid,
    dsp_io_segment_if.slave           bus,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clear_overrun,
    output logic [CW-1:0]             frame_cycles
);

    localparam int unsigned CntMax = 32'({CW{1'b1}});

    io_state_t                 state;
    logic [NCHAN-1:0][DWW-1:0] staging;
    logic [NCHAN-1:0][DWW-1:0] stagingNext;
    logic [NCHAN-1:0][DWW-1:0] inputBank;
    logic [DWW-1:0]            readNext;
    logic [CW-1:0]             cnt;
    logic                      commit;
    logic                      overrunSet;

    assign commit     = (state == IO_RUN) && frame_done;
    assign overrunSet = (state == IO_RUN) && start && !frame_done;

    // Staging bank with this cycle's write applied, so a write landing in
    // the frame_done cycle is part of the commit. Offsets at or beyond NCHAN
    // match no channel and are dropped.
    always_comb begin
        stagingNext = staging;
        for (int k = 0; k < NCHAN; k++) begin
            if (bus.writeEnable && (bus.writeAddress == OffsetWidth'(k))) begin
                stagingNext[k] = bus.writeData;
            end
        end
    end

    // Offsets at or beyond NCHAN read as zero instead of aliasing.
    always_comb begin
        readNext = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (bus.readAddress == OffsetWidth'(k)) begin
                readNext = inputBank[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IO_IDLE;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            out_valid    <= 1'b0;
            cnt          <= '0;
            frame_cycles <= '0;
            staging      <= '0;
            inputBank    <= '0;
            outputs      <= '0;
            bus.readData <= '0;
        end else begin
            staging      <= stagingNext;
            // readNext uses the bank before any capture in this same cycle.
            bus.readData <= readNext;
            out_valid    <= commit;

            if (start) begin
                inputBank <= inputs;
            end

            if (commit) begin
                outputs      <= stagingNext;
                frame_cycles <= cnt;
            end

            if (overrunSet) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IO_IDLE: begin
                    if (start) begin
                        state <= IO_RUN;
                        busy  <= 1'b1;
                        cnt   <= CW'(1);
                    end
                end
                IO_RUN: begin
                    if (start) begin
                        // New frame begins whether or not the old one committed.
                        cnt <= CW'(1);
                    end else begin
                        cnt <= CW'(sat_inc(32'(cnt), CntMax));
                        if (frame_done) begin
                            state <= IO_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_io_segment.sv
// -----------------------------------------------------------------------------
// tb_dsp_io_segment
// Directed bench for dsp_io_segment. A second instance with CW=4 receives the
// same stimulus to exercise frame-counter saturation. Expected read data and
// expected commits are queued when stimulus is driven and compared when the
// DUT responds.
// -----------------------------------------------------------------------------
module tb_dsp_io_segment;

    localparam int DWW   = 36;
    localparam int OW    = 8;
    localparam int NCHAN = 8;
    localparam int CW    = 16;
    localparam int CW2   = 4;

    typedef logic [NCHAN-1:0][DWW-1:0] bank_t;

    typedef struct {
        bank_t outs;
        int    fc;
    } commit_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          frame_done;
    logic          clear_overrun;
    bank_t         inputs;
    bank_t         outputs;
    bank_t         outputs2;
    logic          out_valid;
    logic          out_valid2;
    logic          busy;
    logic          busy2;
    logic          overrun;
    logic          overrun2;
    logic [CW-1:0]  frame_cycles;
    logic [CW2-1:0] frame_cycles2;

    dsp_io_segment_if #(.DWW(DWW), .OffsetWidth(OW)) bus  ();
    dsp_io_segment_if #(.DWW(DWW), .OffsetWidth(OW)) bus2 ();

    assign bus2.readAddress  = bus.readAddress;
    assign bus2.writeAddress = bus.writeAddress;
    assign bus2.writeData    = bus.writeData;
    assign bus2.writeEnable  = bus.writeEnable;

    dsp_io_segment #(.DWW(DWW), .OffsetWidth(OW), .NCHAN(NCHAN), .CW(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .frame_done    (frame_done),
        .inputs        (inputs),
        .outputs       (outputs),
        .out_valid     (out_valid),
        .bus           (bus),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .frame_cycles  (frame_cycles)
    );

    dsp_io_segment #(.DWW(DWW), .OffsetWidth(OW), .NCHAN(NCHAN), .CW(CW2)) dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .frame_done    (frame_done),
        .inputs        (inputs),
        .outputs       (outputs2),
        .out_valid     (out_valid2),
        .bus           (bus2),
        .busy          (busy2),
        .overrun       (overrun2),
        .clear_overrun (clear_overrun),
        .frame_cycles  (frame_cycles2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              nAssert = 0;
    int              nFail   = 0;
    int              cyc     = 0;
    logic [DWW-1:0]  readQ[$];
    commit_t         commitQ[$];
    bit              rdPending  = 0;
    bit              commitFlag = 0;
    bank_t           expOuts;
    int              sCyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOuts(input string tag, input bank_t exp);
        for (int k = 0; k < NCHAN; k++) begin
            check($sformatf("%s[%0d]", tag, k), outputs[k], exp[k]);
        end
    endtask

    // One clock: drive happens before the call, sampling 1 ns after the edge.
    task automatic tick();
        logic [DWW-1:0] rexp;
        commit_t        c;
        bit             expVld;
        @(posedge clk);
        #1;
        cyc++;
        if (rdPending) begin
            rdPending = 0;
            if (readQ.size() == 0) begin
                check("readQ_empty", 64'd1, 64'd0);
            end else begin
                rexp = readQ.pop_front();
                check("readData", bus.readData, rexp);
                check("readData2", bus2.readData, rexp);
            end
        end
        expVld = commitFlag;
        commitFlag = 0;
        check("out_valid", out_valid, expVld);
        check("out_valid2", out_valid2, expVld);
        if (expVld) begin
            if (commitQ.size() == 0) begin
                check("commitQ_empty", 64'd1, 64'd0);
            end else begin
                c = commitQ.pop_front();
                checkOuts("commit_outputs", c.outs);
                check("commit_outputs2", outputs2, c.outs);
                check("frame_cycles", frame_cycles, c.fc);
                check("frame_cycles2", frame_cycles2, (c.fc > 15) ? 15 : c.fc);
            end
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [OW-1:0] addr, input logic [DWW-1:0] data);
        bus.writeAddress = addr;
        bus.writeData    = data;
        bus.writeEnable  = 1'b1;
        tick();
        bus.writeEnable  = 1'b0;
    endtask

    task automatic rd(input logic [OW-1:0] addr, input logic [DWW-1:0] exp);
        bus.readAddress = addr;
        readQ.push_back(exp);
        rdPending = 1;
        tick();
    endtask

    task automatic expectCommit(input bank_t outs, input int fc);
        commit_t c;
        c.outs = outs;
        c.fc   = fc;
        commitQ.push_back(c);
        commitFlag = 1;
    endtask

    task automatic frameDone();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        start            = 1'b0;
        frame_done       = 1'b0;
        clear_overrun    = 1'b0;
        inputs           = '0;
        bus.readAddress  = '0;
        bus.writeAddress = '0;
        bus.writeData    = '0;
        bus.writeEnable  = 1'b0;
        expOuts          = '0;

        // Reset state
        repeat (2) tick();
        checkOuts("rst_outputs", '0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_cycles", frame_cycles, 0);
        check("rst_readData", bus.readData, 0);
        reset_n = 1'b1;

        // Reset mid-frame after staging writes
        pulseStart();
        check("t1_busy_run", busy, 1);
        wr(8'd1, 36'h55);
        wr(8'd5, 36'h66);
        #2;
        reset_n = 1'b0;
        #1;
        checkOuts("t1_rst_outputs", '0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_overrun", overrun, 0);
        check("t1_rst_frame_cycles", frame_cycles, 0);
        check("t1_rst_out_valid", out_valid, 0);
        tick();
        reset_n = 1'b1;
        // Staged writes were discarded: the next commit is all zero.
        pulseStart();
        expectCommit('0, 1);
        frameDone();
        check("t1_busy_idle", busy, 0);

        // Input capture and read path
        for (int k = 0; k < NCHAN; k++) inputs[k] = DWW'(k * 'h111);
        bus.readAddress = 8'd3;
        readQ.push_back('0);
        rdPending = 1;
        sCyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NCHAN; k++) inputs[k] = DWW'('hF00 + k);
        rd(8'd3, 36'h333);
        rd(8'd9, 36'h0);
        rd(8'd7, 36'h777);
        rd(8'd8, 36'h0);
        rd(8'd255, 36'h0);
        rd(8'd0, 36'h0);
        expectCommit('0, cyc - sCyc);
        frameDone();

        // Staging write, out-of-range write dropped, 10-cycle frame
        pulseStart();
        wr(8'd2, 36'hABC);
        wr(8'd20, 36'h5);
        repeat (7) tick();
        expOuts[2] = 36'hABC;
        expectCommit(expOuts, 10);
        frameDone();
        check("t3_busy", busy, 0);
        check("t3_overrun", overrun, 0);
        tick();
        checkOuts("t3_hold", expOuts);

        // Write in the frame_done cycle is forwarded into the commit
        pulseStart();
        repeat (2) tick();
        bus.writeAddress = 8'd0;
        bus.writeData    = 36'h7;
        bus.writeEnable  = 1'b1;
        expOuts[0] = 36'h7;
        expectCommit(expOuts, 3);
        frameDone();
        bus.writeEnable  = 1'b0;

        // Overrun: second start before frame_done, clear in same cycle loses
        pulseStart();
        wr(8'd6, 36'h123);
        repeat (3) tick();
        for (int k = 0; k < NCHAN; k++) inputs[k] = DWW'('h1000 + k);
        start = 1'b1;
        clear_overrun = 1'b1;
        tick();
        start = 1'b0;
        clear_overrun = 1'b0;
        check("t5_overrun_set", overrun, 1);
        check("t5_overrun_set2", overrun2, 1);
        check("t5_busy", busy, 1);
        check("t5_busy2", busy2, 1);
        check("t5_no_commit_ch6", outputs[6], 0);
        rd(8'd5, 36'h1005);
        repeat (2) tick();
        expOuts[6] = 36'h123;
        expectCommit(expOuts, 4);
        frameDone();
        check("t5_overrun_sticky", overrun, 1);
        check("t5_busy_idle", busy, 0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("t5_overrun_cleared", overrun, 0);

        // start and frame_done together in RUN, then a saturating frame
        pulseStart();
        repeat (2) tick();
        wr(8'd1, 36'h99);
        expOuts[1] = 36'h99;
        expectCommit(expOuts, 4);
        start = 1'b1;
        frame_done = 1'b1;
        tick();
        start = 1'b0;
        frame_done = 1'b0;
        check("t6_no_overrun", overrun, 0);
        check("t6_busy", busy, 1);
        repeat (19) tick();
        expectCommit(expOuts, 20);
        frameDone();
        check("t6_fc2_saturated", frame_cycles2, 15);
        check("t6_busy_idle", busy, 0);
        frameDone();
        tick();
        checkOuts("t6_idle_done_hold", expOuts);
        check("t6_idle_fc_hold", frame_cycles, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dsp_io_segment.md
Name: dsp_io_segment

Overview:
Parametrised I/O data-memory segment for the uDSP core. Replaces the fixed 8-channel, unbuffered input/output segment with a version generalised to NCHAN channels. Inputs are double-buffered and snapshotted on each frame start. Outputs are written into a staging bank and committed atomically at frame end. The block also detects frame overrun and measures frame length, and sits behind memCtl as one data segment with 1-cycle read latency.

Parameters:
DWW, 36, sample/data word width
OffsetWidth, 8, segment offset (address) width
NCHAN, 8, number of input and output channels; 1..2^OffsetWidth
CW, 16, frame cycle counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  frame start pulse (same as core start)
frame_done  in  1  program finished for this frame (one-cycle pulse from core)
inputs  in  NCHAN x DWW  live input samples
outputs  out  NCHAN x DWW  committed output samples
out_valid  out  1  one-cycle pulse, high in the cycle outputs first show a new commit
readAddress  in  OffsetWidth  segment read offset from memCtl
readData  out  DWW  read data, 1-cycle latency
writeAddress  in  OffsetWidth  segment write offset
writeData  in  DWW  write data
writeEnable  in  1  segment write enable
busy  out  1  high while a frame is in progress (state RUN)
overrun  out  1  sticky: start arrived before frame_done
clear_overrun  in  1  clears overrun
frame_cycles  out  CW  length of last committed frame in cycles, saturating

Behaviour:
- Single clock clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - outputs, staging bank, input bank, readData, frame_cycles, internal counter: 0.
  - out_valid, busy, overrun: 0.
  - State: IDLE.
- States are IDLE and RUN.
  - IDLE to RUN on start.
  - RUN to IDLE on frame_done without start.
  - RUN with start and frame_done together: commit, stay in RUN.
  - RUN with start only: overrun, stay in RUN.
  - frame_done in IDLE is ignored (no commit, no out_valid).
- Input capture: on every start edge, in either state, input bank <= inputs.
- Read: readData(t+1) = inputBank[readAddress(t)] if readAddress < NCHAN, else 0.
  - A read in the start cycle returns the pre-capture bank value.
  - Addresses at or beyond NCHAN never alias.
- Write: writeEnable with writeAddress < NCHAN updates staging[writeAddress].
  - Accepted in any state; writes to addresses at or beyond NCHAN are dropped.
- Commit (RUN and frame_done):
  - outputs <= staging, including any write in the same cycle (post-write value forwarded).
  - out_valid high for exactly the following cycle.
  - Channels not written this frame keep their previous staged value.
- Frame counter:
  - start sets cnt <= 1.
  - Each RUN cycle without start: cnt <= min(cnt+1, 2^CW-1).
  - On commit: frame_cycles <= cnt. With start at cycle s and frame_done at cycle d, frame_cycles = d-s.
- Overrun: start in RUN without frame_done sets overrun <= 1.
  - No commit occurs; cnt restarts at 1; new inputs are captured.
  - clear_overrun clears overrun; if set and clear occur in the same cycle, set wins.
- Reset mid-frame discards staged data and returns to IDLE with all reset values.
- busy = (state == RUN), registered.

Decomposition:
- dsp_pkg holds:
  - default DWW and OffsetWidth constants;
  - io_state_t enum {IO_IDLE, IO_RUN};
  - a sat_inc function for the CW-wide saturating increment.
- No sub-module; the block stays flat (about 200 lines).

Test Plan:
1. Drive reset_n low mid-RUN after staging writes -> outputs all 0, busy=0, overrun=0, frame_cycles=0, out_valid=0.
2. inputs[k]=k*0x111 with NCHAN=8; pulse start; change inputs next cycle; read addr 3 -> readData=0x333 one cycle later; read addr 9 -> 0.
3. Start; write addr 2=0xABC and addr 20=0x5; frame_done 10 cycles after start -> outputs[2]=0xABC, others unchanged, single out_valid pulse, frame_cycles=10, busy=0.
4. Write addr 0=0x7 in the same cycle as frame_done -> committed outputs[0]=0x7.
5. Start, then start again 5 cycles later, then frame_done 4 cycles after that:
   - overrun=1, no commit at the second start, busy stays 1;
   - at frame_done, frame_cycles=4;
   - pulse clear_overrun -> overrun=0.
6. Start and frame_done together in RUN -> commit, no overrun, busy stays 1. frame_done in IDLE -> no out_valid. With CW=4, a 20-cycle frame -> frame_cycles=15.
